// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the handshaked RISC-V data memory.
//   - RV32I load/store funct3 encodings
//   - FSM state type for the request/response sequencer
//   - is_legal_ls(): funct3 legality check for loads and stores
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Stores only have signed-width encodings; loads add the unsigned forms.
    function automatic logic is_legal_ls(input logic [2:0] funct3, input logic we);
        logic legal;
        if (we) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return legal;
    endfunction

endpackage

// File: rtl/data_memory_hs_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering.
// Ports:
//   ld_word   in  32  raw RAM word
//   ld_offset in  2   byte offset within the word (load)
//   ld_funct3 in  3   load funct3
//   ld_data   out 32  extracted and sign/zero-extended load data
//   st_old    in  32  existing word contents
//   st_wd     in  32  store data (low byte/half used for SB/SH)
//   st_offset in  2   byte offset within the word (store)
//   st_funct3 in  3   store funct3
//   st_word   out 32  merged word
//   st_be     out 4   byte enables of the lanes the store touches
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_funct3,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wd,
    input  logic [1:0]  st_offset,
    input  logic [2:0]  st_funct3,
    output logic [31:0] st_word,
    output logic [3:0]  st_be
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b  = ld_word[{ld_offset, 3'b000} +: 8];
        lane_h  = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = 32'h0;
        case (ld_funct3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ld_data = {24'h0, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ld_data = {16'h0, lane_h};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

    always_comb begin
        st_word = st_old;
        st_be   = 4'b0000;
        case (st_funct3)
            F3_B: begin
                st_be = 4'b0001 << st_offset;
                st_word[{st_offset, 3'b000} +: 8] = st_wd[7:0];
            end
            F3_H: begin
                if (st_offset[1]) begin
                    st_be          = 4'b1100;
                    st_word[31:16] = st_wd[15:0];
                end else begin
                    st_be          = 4'b0011;
                    st_word[15:0]  = st_wd[15:0];
                end
            end
            F3_W: begin
                st_be   = 4'b1111;
                st_word = st_wd;
            end
            default: begin
                st_be   = 4'b0000;
                st_word = st_old;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// data_memory_hs: valid/ready handshaked RV32I data memory.
// One request in flight at a time; loads answer after READ_LATENCY cycles,
// stores after one. Misaligned, out-of-range and illegal-funct3 accesses
// return RSP_ERR=1 with RSP_RD=0 and never write the RAM.
// Ports:
//   CLK, RST_N             clock (rising edge), synchronous active-low reset
//   REQ_VALID/REQ_READY    request handshake
//   REQ_WE, REQ_FUNCT3     1=store/0=load, RV32I funct3
//   REQ_ADDR, REQ_WD       byte address, store data
//   RSP_VALID/RSP_READY    response handshake
//   RSP_RD, RSP_ERR        load data (0 for stores/errors), access fault
module data_memory_hs
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 64,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
)
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WD,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RD,
    output logic        RSP_ERR
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  WAIT_INIT  = 3'(READ_LATENCY - 1);

    mem_state_e       state_reg, state_next;
    logic [2:0]       cnt_reg, cnt_next;
    logic [2:0]       f3_reg;
    logic [1:0]       off_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             err_reg;
    logic             we_reg;

    logic [31:0]      req_off;
    logic [IDX_W-1:0] req_idx;
    logic             misalign;
    logic             req_err;
    logic             accept;
    logic             st_en;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;
    logic [31:0]      st_word;
    logic [3:0]       st_be;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign req_off = REQ_ADDR - BASE_ADDR;
    assign req_idx = req_off[IDX_W+1:2];

    always_comb begin
        misalign = 1'b0;
        case (REQ_FUNCT3)
            F3_H, F3_HU: misalign = REQ_ADDR[0];
            F3_W:        misalign = |REQ_ADDR[1:0];
            default:     misalign = 1'b0;
        endcase
    end

    assign req_err = !is_legal_ls(REQ_FUNCT3, REQ_WE) || misalign ||
                     (REQ_ADDR < BASE_ADDR) || (req_off >= SPAN_BYTES);

    assign accept = REQ_VALID && REQ_READY;
    assign st_en  = accept && REQ_WE && !req_err;

    // The RAM is read once per load: at acceptance when there is no wait
    // phase, otherwise at the last WAIT edge using the latched index.
    assign rd_en  = (accept && !REQ_WE && (READ_LATENCY == 1)) ||
                    ((state_reg == WAIT) && (cnt_reg == 3'd1));
    assign rd_idx = (state_reg == IDLE) ? req_idx : idx_reg;

    mem_lane_align u_align (
        .ld_word   (rd_word),
        .ld_offset (off_reg),
        .ld_funct3 (f3_reg),
        .ld_data   (ld_data),
        .st_old    (32'h0),          // byte enables keep untouched lanes intact
        .st_wd     (REQ_WD),
        .st_offset (REQ_ADDR[1:0]),
        .st_funct3 (REQ_FUNCT3),
        .st_word   (st_word),
        .st_be     (st_be)
    );

    // ------------------------------------------------------------------
    // RAM: one byte-wide array per lane so partial stores need no
    // read-modify-write.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] ram [DEPTH_WORDS];
        logic [7:0] q_reg;

        always_ff @(posedge CLK) begin
            if (st_en && st_be[gi]) begin
                ram[req_idx] <= st_word[8*gi +: 8];
            end
            if (rd_en) begin
                q_reg <= ram[rd_idx];
            end
        end

        assign rd_word[8*gi +: 8] = q_reg;
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            f3_reg    <= 3'd0;
            off_reg   <= 2'd0;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                f3_reg  <= REQ_FUNCT3;
                off_reg <= REQ_ADDR[1:0];
                idx_reg <= req_idx;
                err_reg <= req_err;
                we_reg  <= REQ_WE;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (REQ_WE || (READ_LATENCY == 1)) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd1) begin
                    state_next = RESP;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next   = cnt_reg - 3'd1;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_comb begin
        REQ_READY = RST_N && (state_reg == IDLE);
        RSP_VALID = RST_N && (state_reg == RESP);
        RSP_ERR   = RSP_VALID && err_reg;
        RSP_RD    = (RSP_VALID && !err_reg && !we_reg) ? ld_data : 32'h0;
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs. Three instances:
//   unit 0: READ_LATENCY=1, BASE 0x0000
//   unit 1: READ_LATENCY=3, BASE 0x1000
//   unit 2: READ_LATENCY=4, BASE 0x0000
module tb_data_memory_hs;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [2:0]  req_f3    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wd    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rd    [3];
    logic        rsp_err   [3];

    int lat_tab [3] = '{1, 3, 4};
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        data_memory_hs #(
            .DEPTH_WORDS  (64),
            .READ_LATENCY ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4)),
            .BASE_ADDR    ((gi == 1) ? 32'h0000_1000 : 32'h0000_0000)
        ) dut (
            .CLK        (clk),
            .RST_N      (rst_n[gi]),
            .REQ_VALID  (req_valid[gi]),
            .REQ_READY  (req_ready[gi]),
            .REQ_WE     (req_we[gi]),
            .REQ_FUNCT3 (req_f3[gi]),
            .REQ_ADDR   (req_addr[gi]),
            .REQ_WD     (req_wd[gi]),
            .RSP_VALID  (rsp_valid[gi]),
            .RSP_READY  (rsp_ready[gi]),
            .RSP_RD     (rsp_rd[gi]),
            .RSP_ERR    (rsp_err[gi])
        );
    end

    typedef struct {
        int          u;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        string       name;
    } vec_t;

    vec_t vt [48];
    int   nv = 0;

    task automatic add(input int u, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err, input string name);
        vt[nv].u    = u;
        vt[nv].we   = we;
        vt[nv].f3   = f3;
        vt[nv].addr = addr;
        vt[nv].wd   = wd;
        vt[nv].rd   = rd;
        vt[nv].err  = err;
        vt[nv].name = name;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request, wait for the response, check data/error/latency,
    // then complete the handshake.
    task automatic txn(input int u, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string name);
        int n;
        int lat;
        int exp_lat;
        exp_lat = we ? 1 : lat_tab[u];
        @(negedge clk);
        n = 0;
        while (!req_ready[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " req_ready"}, 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_f3[u]    = f3;
        req_addr[u]  = addr;
        req_wd[u]    = wd;
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid[u]) chk({name, " busy ready"}, 32'(req_ready[u]), 32'd0);
        end while (!rsp_valid[u] && lat < 20);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " rd"}, rsp_rd[u], exp_rd);
        chk({name, " err"}, 32'(rsp_err[u]), 32'(exp_err));
        $display("txn u%0d %s we=%0d f3=%0d addr=%h wd=%h -> rd=%h err=%0d lat=%0d",
                 u, name, we, f3, addr, wd, rsp_rd[u], rsp_err[u], lat);
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[u] = 1'b0;
        @(negedge clk);
        chk({name, " done valid"}, 32'(rsp_valid[u]), 32'd0);
        chk({name, " done ready"}, 32'(req_ready[u]), 32'd1);
    endtask

    initial begin
        int lat;
        for (int u = 0; u < 3; u++) begin
            rst_n[u]     = 1'b0;
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_f3[u]    = 3'd0;
            req_addr[u]  = 32'h0;
            req_wd[u]    = 32'h0;
            rsp_ready[u] = 1'b0;
        end

        // ---------------- vector table ----------------
        // unit 0, latency 1
        add(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, "SW 0x10");
        add(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, "LW 0x10");
        add(0, 1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0,        0, "SW 0x20");
        add(0, 0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 0, "LB 0x23");
        add(0, 0, 3'b100, 32'h23, 32'h0,        32'h00000080, 0, "LBU 0x23");
        add(0, 0, 3'b001, 32'h22, 32'h0,        32'hFFFF80FF, 0, "LH 0x22");
        add(0, 0, 3'b101, 32'h20, 32'h0,        32'h00007F01, 0, "LHU 0x20");
        add(0, 0, 3'b000, 32'h21, 32'h0,        32'h0000007F, 0, "LB 0x21");
        add(0, 0, 3'b000, 32'h22, 32'h0,        32'hFFFFFFFF, 0, "LB 0x22");
        add(0, 0, 3'b100, 32'h22, 32'h0,        32'h000000FF, 0, "LBU 0x22");
        add(0, 0, 3'b001, 32'h20, 32'h0,        32'h00007F01, 0, "LH 0x20");
        add(0, 0, 3'b101, 32'h22, 32'h0,        32'h000080FF, 0, "LHU 0x22");
        add(0, 1, 3'b010, 32'h30, 32'h11223344, 32'h0,        0, "SW 0x30");
        add(0, 1, 3'b000, 32'h31, 32'h000000AA, 32'h0,        0, "SB 0x31");
        add(0, 1, 3'b001, 32'h32, 32'h1234BEEF, 32'h0,        0, "SH 0x32");
        add(0, 0, 3'b010, 32'h30, 32'h0,        32'hBEEFAA44, 0, "LW 0x30");
        add(0, 0, 3'b010, 32'h12, 32'h0,        32'h0,        1, "LW 0x12 misalign");
        add(0, 1, 3'b010, 32'h04, 32'h55667788, 32'h0,        0, "SW 0x04");
        add(0, 1, 3'b001, 32'h05, 32'hFFFFFFFF, 32'h0,        1, "SH 0x05 misalign");
        add(0, 1, 3'b100, 32'h04, 32'hFFFFFFFF, 32'h0,        1, "S f3=100");
        add(0, 0, 3'b010, 32'h04, 32'h0,        32'h55667788, 0, "LW 0x04 intact");
        add(0, 0, 3'b001, 32'h07, 32'h0,        32'h0,        1, "LH 0x07 misalign");
        add(0, 1, 3'b010, 32'hFC, 32'hCAFEF00D, 32'h0,        0, "SW 0xFC top");
        add(0, 0, 3'b010, 32'hFC, 32'h0,        32'hCAFEF00D, 0, "LW 0xFC top");
        add(0, 0, 3'b010, 32'h100, 32'h0,       32'h0,        1, "LW 0x100 range");
        add(0, 1, 3'b010, 32'h100, 32'h0,       32'h0,        1, "SW 0x100 range");
        add(0, 0, 3'b000, 32'h0, 32'h0,         32'h0,        0, "LB 0x00 wraps");
        add(0, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, "L f3=011");
        add(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, "LW 0x10 again");
        // unit 1, latency 3, base 0x1000
        add(1, 1, 3'b010, 32'h1010, 32'h0BADCAFE, 32'h0,        0, "SW 0x1010");
        add(1, 0, 3'b010, 32'h1010, 32'h0,        32'h0BADCAFE, 0, "LW 0x1010");
        add(1, 0, 3'b101, 32'h1012, 32'h0,        32'h00000BAD, 0, "LHU 0x1012");
        add(1, 0, 3'b010, 32'h0FFC, 32'h0,        32'h0,        1, "LW below base");
        add(1, 0, 3'b010, 32'h1100, 32'h0,        32'h0,        1, "LW 0x1100 range");
        add(1, 0, 3'b010, 32'h0010, 32'h0,        32'h0,        1, "LW 0x10 no base");

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d reset req_ready", u), 32'(req_ready[u]), 32'd0);
            chk($sformatf("u%0d reset rsp_valid", u), 32'(rsp_valid[u]), 32'd0);
            chk($sformatf("u%0d reset rsp_rd", u), rsp_rd[u], 32'h0);
            chk($sformatf("u%0d reset rsp_err", u), 32'(rsp_err[u]), 32'd0);
            rst_n[u] = 1'b1;
        end
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d idle req_ready", u), 32'(req_ready[u]), 32'd1);
        end
        // Unit 0's bytes at 0x00 are never written before "LB 0x00 wraps";
        // seed that word so the expectation is defined.
        txn(0, 1, 3'b010, 32'h0, 32'h00000000, 32'h0, 0, "SW 0x00 seed");

        for (int i = 0; i < nv; i++) begin
            txn(vt[i].u, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd,
                vt[i].rd, vt[i].err, vt[i].name);
        end

        // ---------------- latency 3 with backpressure ----------------
        txn(1, 1, 3'b010, 32'h1020, 32'h13579BDF, 32'h0, 0, "SW 0x1020");
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_f3[1]    = 3'b010;
        req_addr[1]  = 32'h1020;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[1] && lat < 20);
        chk("bp latency", 32'(lat), 32'd3);
        // Offer a competing store while the response is held; it must not land.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_wd[1]    = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d valid", c), 32'(rsp_valid[1]), 32'd1);
            chk($sformatf("bp hold%0d rd", c), rsp_rd[1], 32'h13579BDF);
            chk($sformatf("bp hold%0d req_ready", c), 32'(req_ready[1]), 32'd0);
        end
        $display("txn u1 LW 0x1020 held 5 cycles rd=%h", rsp_rd[1]);
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        chk("bp release valid", 32'(rsp_valid[1]), 32'd0);
        chk("bp release ready", 32'(req_ready[1]), 32'd1);
        txn(1, 0, 3'b010, 32'h1020, 32'h0, 32'h13579BDF, 0, "LW 0x1020 after bp");

        // ---------------- reset during WAIT, latency 4 ----------------
        txn(2, 1, 3'b010, 32'h40, 32'hA5A55A5A, 32'h0, 0, "SW 0x40");
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_f3[2]    = 3'b010;
        req_addr[2]  = 32'h40;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("rst wait valid", 32'(rsp_valid[2]), 32'd0);
        chk("rst wait ready", 32'(req_ready[2]), 32'd0);
        rst_n[2] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst in%0d ready", c), 32'(req_ready[2]), 32'd0);
            chk($sformatf("rst in%0d valid", c), 32'(rsp_valid[2]), 32'd0);
        end
        rst_n[2] = 1'b1;
        @(negedge clk);
        chk("rst release ready", 32'(req_ready[2]), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rst after%0d valid", c), 32'(rsp_valid[2]), 32'd0);
        end
        $display("txn u2 LW 0x40 aborted by reset");
        txn(2, 0, 3'b010, 32'h40, 32'h0, 32'hA5A55A5A, 0, "LW 0x40 after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- Parametrised, handshaked successor to the single-cycle RISC-V data memory.
- Accepts one load/store request at a time over a valid/ready interface and supports LB/LBU/LH/LHU/LW/SB/SH/SW.
- Read latency is configurable, and misaligned or out-of-range accesses are reported as errors instead of silently aliasing.
- Sits between the MEM stage / LSU and the word-addressed data RAM.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, >= 4.
- READ_LATENCY, 1, cycles from load acceptance to RSP_VALID; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RV32I load/store funct3.
- REQ_ADDR  in  32  byte address.
- REQ_WD  in  32  store data; low byte/half used for SB/SH.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer takes response.
- RSP_RD  out  32  load data, extended per funct3; 0 for stores and errors.
- RSP_ERR  out  1  access fault (misaligned, out of range, or illegal funct3).

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - Outputs go to REQ_READY=0 during reset, then 1 in IDLE; RSP_VALID=0, RSP_RD=0, RSP_ERR=0.
  - FSM goes to IDLE and the latency counter goes to 0.
  - RAM contents are not reset.
- Reset mid-operation: any in-flight load is discarded with no response. A store already committed stays committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - REQ_READY=1.
  - Acceptance happens on an edge where REQ_VALID && REQ_READY. At that edge, latch funct3, offset, word index and the error flag.
- Store acceptance:
  - If there is no error, commit the byte/half/word write at the acceptance edge.
  - Go to RESP; RSP_VALID rises the next cycle (latency 1).
- Load acceptance:
  - If READ_LATENCY=1, go to RESP.
  - Otherwise go to WAIT with counter = READ_LATENCY-1.
- WAIT: decrement the counter each cycle; at 1, go to RESP. RSP_RD is registered from the RAM word read at the final edge.
- RESP:
  - RSP_VALID=1, and RSP_RD/RSP_ERR are held stable until RSP_READY.
  - On an edge with RSP_READY=1, go to IDLE. REQ_READY is 0 in WAIT and RESP, so there is no back-to-back overlap.
  - Throughput: 1 request per READ_LATENCY+1 cycles when RSP_READY is tied high.
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
  - (addr-BASE_ADDR) >= DEPTH_WORDS*4, or addr < BASE_ADDR.
- On error: no RAM write, RSP_RD=0, RSP_ERR=1, and the same latency as a good access.
- Load extraction:
  - LB/LBU select the byte lane by addr[1:0]; LH/LHU select the half by addr[1]. LW returns the whole word.
  - Signed variants sign-extend from the top bit of the selected lane; unsigned variants zero-extend.
- Store merge: SB writes only the lane addr[1:0] using WD[7:0], SH writes the half addr[1] using WD[15:0], SW writes all 32 bits; other bits are unchanged.
- Word index is (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Request inputs are don't-care when REQ_VALID=0 or REQ_READY=0.

Decomposition:
- Package riscv_mem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state enum {IDLE, WAIT, RESP}.
  - Function is_legal_ls(funct3, we).
- Sub-module mem_lane_align (combinational):
  - Load path: word plus offset plus funct3 give the extended RD.
  - Store path: old word, WD, offset and funct3 give the merged word plus a 4-bit byte enable.
  - Shared by the future cache fill path.

Test Plan:
1. Reset and SW/LW, READ_LATENCY=1: after RST_N pulse, SW 0xDEADBEEF @0x10 → RSP_VALID 1 cycle after accept with RSP_ERR=0. Then LW @0x10 → RSP_RD=0xDEADBEEF.
2. Byte/half extraction: after word 0x80FF7F01 @0x20:
   - LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080.
   - LH @0x22 → 0xFFFF80FF; LHU @0x20 → 0x00007F01.
3. Partial stores: word @0x30 = 0x11223344, then SB 0xAA @0x31 and SH 0xBEEF @0x32 → LW @0x30 = 0xBEEFAA44.
4. Errors:
   - LW @0x12 → RSP_ERR=1, RSP_RD=0.
   - SH @0x05 → RSP_ERR=1, memory unchanged.
   - LW @0x100 with DEPTH_WORDS=64 → RSP_ERR=1.
   - funct3=011 → RSP_ERR=1.
5. Latency and backpressure, READ_LATENCY=3: RSP_VALID exactly 3 cycles after accept. With RSP_READY held 0 for 5 cycles, RSP_RD stays stable and REQ_READY=0 throughout; the response completes on the first RSP_READY=1 edge.
6. Reset mid-load, READ_LATENCY=4: RST_N=0 in WAIT → RSP_VALID never rises, and REQ_READY=1 the cycle after reset is released. A subsequent LW returns the pre-reset data.
